// File: rtl/mdu_pkg.sv
// Shared op codes, FSM state type and operand-signedness helpers for the RV32M unit.
package mdu_pkg;

    localparam logic [3:0] OP_MUL    = 4'b1000;
    localparam logic [3:0] OP_MULH   = 4'b1001;
    localparam logic [3:0] OP_MULHSU = 4'b1010;
    localparam logic [3:0] OP_MULHU  = 4'b1011;
    localparam logic [3:0] OP_DIV    = 4'b1100;
    localparam logic [3:0] OP_DIVU   = 4'b1101;
    localparam logic [3:0] OP_REM    = 4'b1110;
    localparam logic [3:0] OP_REMU   = 4'b1111;

    typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

    function automatic logic is_signed_a(input logic [3:0] op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input logic [3:0] op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration: LSB-first shift-add multiply or MSB-first restoring divide.
// Zero latency; no flow control of its own.
module mdu_iter_step #(
    parameter int W = 32
) (
    input  logic         i_is_div,
    input  logic [2*W:0] i_acc,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [2*W:0] o_acc,
    output logic [W-1:0] o_b
);

    logic [W:0]   w_sum;
    logic [W:0]   w_rem_sh;
    logic [W+1:0] w_diff;
    logic         w_ge;

    always_comb begin
        w_sum    = i_acc[2*W:W] + {1'b0, (i_b[0] ? i_a : {W{1'b0}})};
        w_rem_sh = {i_acc[W-1:0], i_b[W-1]};
        w_diff   = {1'b0, w_rem_sh} - {2'b00, i_a};
        w_ge     = ~w_diff[W+1];
        if (i_is_div) begin
            // quotient bits shift into the dividend register as dividend bits shift out
            o_acc = {{W{1'b0}}, (w_ge ? w_diff[W:0] : w_rem_sh)};
            o_b   = {i_b[W-2:0], w_ge};
        end else begin
            o_acc = {1'b0, w_sum, i_acc[W-1:1]};
            o_b   = {1'b0, i_b[W-1:1]};
        end
    end

endmodule

// File: rtl/mdu_responder.sv
// Multi-cycle RV32M multiply/divide responder; fixed DATA_WIDTH+1 cycle latency for every op.
// Result is held in DONE until rsp_ready; no new request is taken until the unit is back in IDLE.
module mdu_responder
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    Result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    state_t                   r_state;
    logic [OPCODE_LENGTH-1:0] r_op;
    logic [W-1:0]             r_a, r_b, r_srca, r_result;
    logic [2*W:0]             r_acc;
    logic [CW-1:0]            r_cnt;
    logic                     r_sa, r_sb, r_div0, r_ovf, r_rsp_valid;

    logic                     w_sa, w_sb;
    logic [2*W:0]             w_acc_nxt;
    logic [W-1:0]             w_b_nxt, w_fix, w_quo, w_rem;
    logic [2*W-1:0]           w_prod;

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign Result    = r_result;

    assign w_sa = is_signed_a(Operation) & SrcA[W-1];
    assign w_sb = is_signed_b(Operation) & SrcB[W-1];

    mdu_iter_step #(.W(W)) u_step (
        .i_is_div (r_op[2]),
        .i_acc    (r_acc),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_acc    (w_acc_nxt),
        .o_b      (w_b_nxt)
    );

    always_comb begin
        w_prod = (r_sa ^ r_sb) ? -r_acc[2*W-1:0] : r_acc[2*W-1:0];
        w_quo  = (r_sa ^ r_sb) ? -r_b : r_b;
        w_rem  = r_sa ? -r_acc[W-1:0] : r_acc[W-1:0];
        w_fix  = '0;
        case (r_op)
            OP_MUL:                       w_fix = w_prod[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix = w_prod[2*W-1:W];
            OP_DIV:  w_fix = r_div0 ? '1 : (r_ovf ? MOST_NEG : w_quo);
            OP_DIVU: w_fix = r_div0 ? '1 : r_b;
            OP_REM:  w_fix = r_div0 ? r_srca : (r_ovf ? '0 : w_rem);
            OP_REMU: w_fix = r_div0 ? r_srca : r_acc[W-1:0];
            default: w_fix = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_srca      <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_div0      <= 1'b0;
            r_ovf       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_result    <= '0;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    // magnitudes feed the unsigned datapath; signs are reapplied in FIXUP
                    r_op    <= Operation;
                    r_sa    <= w_sa;
                    r_sb    <= w_sb;
                    r_b     <= w_sa ? -SrcA : SrcA;
                    r_a     <= w_sb ? -SrcB : SrcB;
                    r_srca  <= SrcA;
                    r_div0  <= (SrcB == '0);
                    r_ovf   <= (SrcA == MOST_NEG) && (SrcB == '1);
                    r_acc   <= '0;
                    r_cnt   <= CW'(DATA_WIDTH);
                    r_state <= BUSY;
                end
                BUSY: begin
                    r_acc <= w_acc_nxt;
                    r_b   <= w_b_nxt;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) r_state <= FIXUP;
                end
                FIXUP: begin
                    r_result    <= w_fix;
                    r_rsp_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: if (rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
